// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and sequencer-state definitions for the shared ALU block.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam int FLG_V = 3;
  localparam int FLG_C = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU; v/cout only meaningful for ADD/SUB, undefined opcodes yield 0.
module ALU
  import alu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  ALUcontrol,
  output logic [31:0] Result,
  output logic [3:0]  flags
);

  logic        is_sub;
  logic        is_arith;
  logic [31:0] b_mux;
  logic [32:0] sum;

  always_comb begin
    is_sub   = (ALUcontrol == ALU_SUB);
    is_arith = (ALUcontrol == ALU_ADD) || is_sub;
    b_mux    = is_sub ? ~B : B;
    sum      = {1'b0, A} + {1'b0, b_mux} + {32'd0, is_sub};

    case (ALUcontrol)
      ALU_ADD, ALU_SUB: Result = sum[31:0];
      ALU_AND:          Result = A & B;
      ALU_OR:           Result = A | B;
      ALU_XOR:          Result = A ^ B;
      ALU_SLT:          Result = {31'd0, $signed(A) < $signed(B)};
      ALU_SLL:          Result = A << B[4:0];
      ALU_SRL:          Result = A >> B[4:0];
      ALU_SRA:          Result = 32'($signed(A) >>> B[4:0]);
      ALU_SLTU:         Result = {31'd0, A < B};
      default:          Result = 32'd0;
    endcase

    flags        = 4'd0;
    flags[FLG_V] = is_arith && (A[31] == b_mux[31]) && (sum[31] != A[31]);
    flags[FLG_C] = is_arith && sum[32];
    flags[FLG_N] = Result[31];
    flags[FLG_Z] = (Result == 32'd0);
  end

endmodule

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-requester round-robin grant: a tie goes to the port that was not granted last.
module rr_arb2 (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    case (req_valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters: accept (IDLE), compute/capture (EXEC), hold response (RESP).
module alu_share_arb
  import alu_pkg::*;
#(
  localparam int NPORT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req_valid,
  output logic [NPORT-1:0] req_ready,
  input  logic [31:0]      req_A0,
  input  logic [31:0]      req_B0,
  input  logic [3:0]       req_ALUcontrol0,
  input  logic [31:0]      req_A1,
  input  logic [31:0]      req_B1,
  input  logic [3:0]       req_ALUcontrol1,
  output logic [NPORT-1:0] rsp_valid,
  input  logic [NPORT-1:0] rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             busy
);

  state_t      state_q, state_d;
  logic        last_grant_q, cur_port_q;
  logic [31:0] op_a_q, op_b_q, res_q;
  logic [3:0]  op_ctl_q, flg_q;
  logic [1:0]  gnt;
  logic        accept, rsp_done;
  logic [31:0] alu_res;
  logic [3:0]  alu_flg;

  rr_arb2 u_arb (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  ALU u_alu (
    .A          (op_a_q),
    .B          (op_b_q),
    .ALUcontrol (op_ctl_q),
    .Result     (alu_res),
    .flags      (alu_flg)
  );

  assign accept   = (state_q == ST_IDLE) && (gnt != 2'b00);
  assign rsp_done = rsp_ready[cur_port_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE) ? gnt : 2'b00;
    rsp_valid  = 2'b00;
    if (state_q == ST_RESP) rsp_valid = cur_port_q ? 2'b10 : 2'b01;
    busy       = (state_q != ST_IDLE);
    rsp_result = res_q;
    rsp_flags  = flg_q;
  end

  // Operands come from the granted port; the response registers load only in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cur_port_q   <= 1'b0;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      op_ctl_q     <= 4'd0;
      res_q        <= 32'd0;
      flg_q        <= 4'd0;
    end else begin
      if (accept) begin
        last_grant_q <= gnt[1];
        cur_port_q   <= gnt[1];
        op_a_q       <= gnt[1] ? req_A1 : req_A0;
        op_b_q       <= gnt[1] ? req_B1 : req_B0;
        op_ctl_q     <= gnt[1] ? req_ALUcontrol1 : req_ALUcontrol0;
      end
      if (state_q == ST_EXEC) begin
        res_q <= alu_res;
        flg_q <= alu_flg;
      end
    end
  end

endmodule
